// File: rtl/mux41_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux41_rr_arbiter
//
// Round-robin arbiter that shares one MUX41X2 datapath among four requesters.
// It drives the mux select pins and returns a one-hot grant. Every change of
// the select value is followed by one settle cycle with no grant, so a
// requester only launches data once the mux path is stable. An optional hold
// limit forces rotation when other requesters are waiting.
//
// Parameters
//   MAX_HOLD : grant cycles before forced rotation while others pend (0 = none)
//   HOLD_W   : hold counter width, 2**HOLD_W > MAX_HOLD
//
// Ports
//   clk   in   1  clock, rising edge
//   rstb  in   1  asynchronous active-low reset
//   req   in   4  req[k]=1: requester k wants mux input IN(k+1)
//   gnt   out  4  one-hot grant, registered
//   s0    out  1  MUX41X2.S0 (= idx[1]), registered
//   s1    out  1  MUX41X2.S1 (= idx[0]), registered
//   busy  out  1  arbiter not idle, registered
// -----------------------------------------------------------------------------

// Protocol checker: grant shape, select stability and grant legality.
module mux41_rr_arbiter_chk (
    input logic       clk,
    input logic       rstb,
    input logic [3:0] req,
    input logic [3:0] gnt,
    input logic       s0,
    input logic       s1
);

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rstb)
        $onehot0(gnt));

    a_sel_stable : assert property (@(posedge clk) disable iff (!rstb)
        (gnt != 4'b0000) |-> $stable({s1, s0}));

    a_gnt_had_req : assert property (@(posedge clk) disable iff (!rstb)
        (gnt != 4'b0000) |-> ((gnt & $past(req)) == gnt));

endmodule

module mux41_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GRANT  = 2'd2
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic              HOLD_EN  = (MAX_HOLD != 0);

    state_t            state_r, state_s;
    logic [1:0]        ptr_r, ptr_s;
    logic [1:0]        idx_r, idx_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [3:0]        gnt_r, gnt_s;
    logic              s0_r, s0_s;
    logic              s1_r, s1_s;
    logic              busy_r, busy_s;
    logic [1:0]        pick_s;
    logic [3:0]        other_s;
    logic              release_s;

    // First set request bit searching p, p+1, p+2, p+3 (mod 4).
    function automatic logic [1:0] pick_next(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] k;
        logic [1:0] res;
        res = p;
        // Walk from farthest to nearest so the nearest hit overwrites.
        for (int j = 3; j >= 0; j--) begin
            k = p + 2'(j);
            if (r[k]) begin
                res = k;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    // Next-state, next-select and next-grant decode.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        idx_s     = idx_r;
        hold_s    = hold_r;
        gnt_s     = gnt_r;
        s0_s      = s0_r;
        s1_s      = s1_r;
        pick_s    = pick_next(req, ptr_r);
        other_s   = req & ~onehot(idx_r);
        release_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                gnt_s = 4'b0000;
                if (req != 4'b0000) begin
                    idx_s   = pick_s;
                    s1_s    = pick_s[0];
                    s0_s    = pick_s[1];
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (req[idx_r]) begin
                    gnt_s   = onehot(idx_r);
                    hold_s  = {HOLD_W{1'b0}};
                    state_s = ST_GRANT;
                end else begin
                    // Withdrawn before the grant: skip past it next time.
                    gnt_s   = 4'b0000;
                    ptr_s   = idx_r + 2'd1;
                    state_s = ST_IDLE;
                end
            end

            ST_GRANT: begin
                release_s = !req[idx_r] ||
                            (HOLD_EN && (hold_r == HOLD_MAX) && (other_s != 4'b0000));
                if (release_s) begin
                    gnt_s = 4'b0000;
                    ptr_s = idx_r + 2'd1;
                    if (req != 4'b0000) begin
                        // The current owner is last in this search order, so
                        // a hold-limit release always lands on another requester.
                        idx_s   = pick_next(req, idx_r + 2'd1);
                        s1_s    = idx_s[0];
                        s0_s    = idx_s[1];
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    gnt_s = onehot(idx_r);
                    if (hold_r != HOLD_MAX) begin
                        hold_s = hold_r + HOLD_W'(1);
                    end else begin
                        hold_s = hold_r;
                    end
                end
            end

            default: begin
                gnt_s   = 4'b0000;
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            idx_r   <= 2'd0;
            hold_r  <= {HOLD_W{1'b0}};
            gnt_r   <= 4'b0000;
            s0_r    <= 1'b0;
            s1_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            idx_r   <= idx_s;
            hold_r  <= hold_s;
            gnt_r   <= gnt_s;
            s0_r    <= s0_s;
            s1_r    <= s1_s;
            busy_r  <= busy_s;
        end
    end

    assign gnt  = gnt_r;
    assign s0   = s0_r;
    assign s1   = s1_r;
    assign busy = busy_r;

    mux41_rr_arbiter_chk u_chk (
        .clk  (clk),
        .rstb (rstb),
        .req  (req),
        .gnt  (gnt),
        .s0   (s0),
        .s1   (s1)
    );

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
module tb_mux41_rr_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rstb;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // reference model: who owns the mux, in which phase
    int m_ptr;
    int m_cand;
    int m_sel;
    int m_hold;
    bit m_settle;
    bit m_grant;

    always #5 clk = ~clk;

    mux41_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(5)) dut (
        .clk  (clk),
        .rstb (rstb),
        .req  (req),
        .gnt  (gnt),
        .s0   (s0),
        .s1   (s1),
        .busy (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {S1,S0} for requester k: S1 = k[0], S0 = k[1]
    function automatic logic [1:0] enc(input int k);
        logic [1:0] kk;
        kk = k[1:0];
        return {kk[0], kk[1]};
    endfunction

    function automatic int search(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++) begin
            if (r[(p + j) % 4]) return (p + j) % 4;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cand = 0; m_sel = 0; m_hold = 0;
        m_settle = 1'b0; m_grant = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] others;
        bit rel;
        if (m_grant) begin
            others = r & ~(4'b0001 << m_cand);
            rel = !r[m_cand] || (MAXH != 0 && m_hold == MAXH && others != 4'b0000);
            if (rel) begin
                m_grant = 1'b0;
                m_ptr = (m_cand + 1) % 4;
                if (r != 4'b0000) begin
                    m_cand = search(r, m_ptr);
                    m_sel = m_cand;
                    m_settle = 1'b1;
                end
            end else if (m_hold < MAXH) begin
                m_hold = m_hold + 1;
            end
        end else if (m_settle) begin
            m_settle = 1'b0;
            if (r[m_cand]) begin
                m_grant = 1'b1;
                m_hold = 0;
            end else begin
                m_ptr = (m_cand + 1) % 4;
            end
        end else if (r != 4'b0000) begin
            m_cand = search(r, m_ptr);
            m_sel = m_cand;
            m_settle = 1'b1;
        end
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        req = 4'b0000;
        #2;
        checks++;
        if ({gnt, s1, s0, busy} !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b s1s0=%b%b busy=%b, expected all 0", gnt, s1, s0, busy);
        end
        tick();
        rstb = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0001;
        tick();
        checks++;
        if ({gnt, s1, s0, busy} !== {4'b0000, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL single_settle: got gnt=%b s1s0=%b%b busy=%b, expected 0000 00 1", gnt, s1, s0, busy);
        end
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b, expected 0001", gnt);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL single_release: got gnt=%b busy=%b, expected 0000 0", gnt, busy);
        end
    endtask

    task automatic test_rotation();
        int order[6];
        logic [3:0] exp_g;
        order = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req = 4'b1111;
        tick();
        checks++;
        if ({gnt, s1, s0} !== {4'b0000, 2'b00}) begin
            errors++;
            $display("FAIL rot_first_settle: got gnt=%b s1s0=%b%b, expected 0000 00", gnt, s1, s0);
        end
        for (int gi = 0; gi < 5; gi++) begin
            exp_g = 4'b0001 << order[gi];
            for (int c = 0; c <= MAXH; c++) begin
                tick();
                checks++;
                if ({gnt, s1, s0} !== {exp_g, enc(order[gi])}) begin
                    errors++;
                    $display("FAIL rot_grant%0d_c%0d: got gnt=%b s1s0=%b%b, expected %b %b",
                             gi, c, gnt, s1, s0, exp_g, enc(order[gi]));
                end
            end
            tick();
            checks++;
            if ({gnt, s1, s0, busy} !== {4'b0000, enc(order[gi + 1]), 1'b1}) begin
                errors++;
                $display("FAIL rot_gap%0d: got gnt=%b s1s0=%b%b busy=%b, expected 0000 %b 1",
                         gi, gnt, s1, s0, busy, enc(order[gi + 1]));
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL rot_abort: got gnt=%b busy=%b, expected 0000 0", gnt, busy);
        end
    endtask

    task automatic test_no_rotation();
        req = 4'b0100;
        tick();
        tick();
        for (int c = 0; c < 40; c++) begin
            checks++;
            if ({gnt, s1, s0} !== {4'b0100, 2'b01}) begin
                errors++;
                $display("FAIL hold_solo_c%0d: got gnt=%b s1s0=%b%b, expected 0100 01", c, gnt, s1, s0);
            end
            tick();
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL hold_solo_release: got gnt=%b busy=%b, expected 0000 0", gnt, busy);
        end
    endtask

    task automatic test_withdraw();
        req = 4'b0010;
        tick();
        checks++;
        if ({gnt, s1, s0, busy} !== {4'b0000, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL withdraw_settle: got gnt=%b s1s0=%b%b busy=%b, expected 0000 10 1", gnt, s1, s0, busy);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL withdraw_abort: got gnt=%b busy=%b, expected 0000 0", gnt, busy);
        end
        req = 4'b1111;
        tick();
        checks++;
        if ({s1, s0} !== 2'b01) begin
            errors++;
            $display("FAIL withdraw_next_ptr: got s1s0=%b%b, expected 01", s1, s0);
        end
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL withdraw_next_grant: got gnt=%b, expected 0100", gnt);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        req = 4'b1000;
        tick();
        tick();
        checks++;
        if ({gnt, s1, s0} !== {4'b1000, 2'b11}) begin
            errors++;
            $display("FAIL areset_pre_grant: got gnt=%b s1s0=%b%b, expected 1000 11", gnt, s1, s0);
        end
        #2;
        rstb = 1'b0;
        #1;
        checks++;
        if ({gnt, s1, s0, busy} !== 7'b0000000) begin
            errors++;
            $display("FAIL areset_async: got gnt=%b s1s0=%b%b busy=%b, expected all 0", gnt, s1, s0, busy);
        end
        tick();
        rstb = 1'b1;
        req = 4'b1010;
        tick();
        checks++;
        if ({s1, s0} !== 2'b10) begin
            errors++;
            $display("FAIL areset_restart_sel: got s1s0=%b%b, expected 10", s1, s0);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL areset_restart_grant: got gnt=%b, expected 0010", gnt);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 9))
                0, 1:    req = 4'($urandom_range(0, 15));
                2:       req = 4'b0000;
                3:       req = 4'b1111;
                default: req = req;
            endcase
            tick();
            model_step(req);
            exp_g = m_grant ? (4'b0001 << m_cand) : 4'b0000;
            checks++;
            if ({gnt, s1, s0, busy} !== {exp_g, enc(m_sel), (m_grant | m_settle)}) begin
                errors++;
                $display("FAIL random_c%0d: req=%b got gnt=%b s1s0=%b%b busy=%b, expected %b %b %b",
                         c, req, gnt, s1, s0, busy, exp_g, enc(m_sel), (m_grant | m_settle));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_no_rotation();
        test_withdraw();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
